// File: rtl/mem_pkg.sv
// Shared constants for the memory-bus arbiter: FSM encoding and the full-word byte enable.
package mem_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t IF_ACT = 2'd1;
  localparam arb_state_t DT_ACT = 2'd2;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant select between fetch and data; data wins unless the fetch side has been starved.
module mem_arb_prio (
  input  logic req_if,
  input  logic req_dt,
  input  logic streak_full,
  output logic grant_if,
  output logic grant_dt
);

  always_comb begin
    grant_dt = req_dt & ~(req_if & streak_full);
    grant_if = req_if & ~grant_dt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, holding each granted
// request on the bus until the memory acks it and returning data plus a one-cycle ack.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_ce,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_data,
  output logic        o_if_ack,
  input  logic        i_dt_req,
  input  logic        i_dt_we,
  input  logic [3:0]  i_dt_be,
  input  logic [31:0] i_dt_addr,
  input  logic [31:0] i_dt_wdata,
  output logic [31:0] o_dt_rdata,
  output logic        o_dt_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_hz_mem
);

  localparam logic [3:0] StreakMax = 4'(STARVE_MAX);

  arb_state_t  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] dt_rdata_q, dt_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dt_ack_q, dt_ack_d;

  logic done, arb_en, req_if, req_dt, grant_if, grant_dt;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{i_if_addr[1:0], i_dt_addr[1:0]};

  assign done   = i_clk_ce & mem_req_q & i_mem_ack;
  assign arb_en = i_clk_ce & ((state_q == IDLE) | done);

  // The owner being completed and a requester still showing its ack must not be re-granted.
  assign req_if = i_if_req & ~if_ack_q & ~(done & (state_q == IF_ACT));
  assign req_dt = i_dt_req & ~dt_ack_q & ~(done & (state_q == DT_ACT));

  mem_arb_prio u_prio (
    .req_if      (req_if),
    .req_dt      (req_dt),
    .streak_full (streak_q == StreakMax),
    .grant_if    (grant_if),
    .grant_dt    (grant_dt)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    dt_rdata_d  = dt_rdata_q;
    if_ack_d    = if_ack_q;
    dt_ack_d    = dt_ack_q;

    if (i_clk_ce) begin
      if_ack_d = 1'b0;
      dt_ack_d = 1'b0;
    end

    if (done) begin
      if (state_q == IF_ACT) begin
        if_ack_d  = 1'b1;
        if_data_d = i_mem_rdata;
      end else begin
        dt_ack_d = 1'b1;
        if (!mem_we_q) dt_rdata_d = i_mem_rdata;
      end
      mem_req_d = 1'b0;
      state_d   = IDLE;
    end

    if (arb_en && grant_dt) begin
      state_d     = DT_ACT;
      mem_req_d   = 1'b1;
      mem_we_d    = i_dt_we;
      mem_be_d    = i_dt_we ? i_dt_be : BE_WORD;
      mem_addr_d  = {i_dt_addr[31:2], 2'b00};
      mem_wdata_d = i_dt_wdata;
      if (!req_if)                    streak_d = '0;
      else if (streak_q != StreakMax) streak_d = streak_q + 4'd1;
    end else if (arb_en && grant_if) begin
      state_d     = IF_ACT;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_be_d    = BE_WORD;
      mem_addr_d  = {i_if_addr[31:2], 2'b00};
      mem_wdata_d = '0;
      streak_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      dt_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dt_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      dt_rdata_q  <= dt_rdata_d;
      if_ack_q    <= if_ack_d;
      dt_ack_q    <= dt_ack_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_data   = if_data_q;
  assign o_dt_rdata  = dt_rdata_q;
  assign o_if_ack    = if_ack_q;
  assign o_dt_ack    = dt_ack_q;
  assign o_hz_mem    = i_if_req & ~if_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected bus transactions are queued as requests are raised
// and popped when a grant appears on the bus.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk, rst_n, ce;
  logic        if_req, if_ack, dt_req, dt_we, dt_ack;
  logic [31:0] if_addr, if_data, dt_addr, dt_wdata, dt_rdata;
  logic [3:0]  dt_be, mem_be;
  logic        mem_req, mem_we, mem_ack, hz;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int if_ack_cnt = 0;
  int dt_ack_cnt = 0;
  int base_if, base_dt;
  bus_t exp_q[$];

  mem_arbiter #(.STARVE_MAX(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clk_ce    (ce),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_data   (if_data),
    .o_if_ack    (if_ack),
    .i_dt_req    (dt_req),
    .i_dt_we     (dt_we),
    .i_dt_be     (dt_be),
    .i_dt_addr   (dt_addr),
    .i_dt_wdata  (dt_wdata),
    .o_dt_rdata  (dt_rdata),
    .o_dt_ack    (dt_ack),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_be    (mem_be),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_hz_mem    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ack pulses counted once per enabled edge.
  always @(posedge clk) begin
    if (ce && if_ack) if_ack_cnt <= if_ack_cnt + 1;
    if (ce && dt_ack) dt_ack_cnt <= dt_ack_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus_t e;
    e.we = we; e.be = be; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic expect_grant(input string tag);
    bus_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s observed=grant expected=no_pending_entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".req"},   32'(mem_req), 32'h1);
      check({tag, ".we"},    32'(mem_we),  32'(e.we));
      check({tag, ".be"},    32'(mem_be),  32'(e.be));
      check({tag, ".addr"},  mem_addr,     e.addr);
      check({tag, ".wdata"}, mem_wdata,    e.wdata);
    end
  endtask

  task automatic set_dt(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
    dt_req = 1'b1; dt_we = we; dt_be = be; dt_addr = addr; dt_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dt_req = 1'b0; dt_we = 1'b0; dt_be = '0; dt_addr = '0; dt_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst.mem_req", 32'(mem_req), 32'h0);
    check("rst.if_ack",  32'(if_ack),  32'h0);
    check("rst.dt_ack",  32'(dt_ack),  32'h0);
    check("rst.addr",    mem_addr,     32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch only, memory acks after two cycles.
    base_if = if_ack_cnt;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    push_bus(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1 check("f1.hz_req", 32'(hz), 32'h1);
    tick();
    expect_grant("f1.grant");
    tick();
    check("f1.wait_req", 32'(mem_req), 32'h1);
    check("f1.wait_ack", 32'(if_ack),  32'h0);
    check("f1.wait_hz",  32'(hz),      32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0;
    check("f1.ack",     32'(if_ack),  32'h1);
    check("f1.data",    if_data,      32'h0000_0013);
    check("f1.req_off", 32'(mem_req), 32'h0);
    check("f1.hz_ack",  32'(hz),      32'h0);
    tick();
    if_req = 1'b0;
    check("f1.no_regrant", 32'(mem_req), 32'h0);
    check("f1.ack_clr",    32'(if_ack),  32'h0);
    check("f1.data_hold",  if_data,      32'h0000_0013);
    check("f1.ack_count",  32'(if_ack_cnt - base_if), 32'h1);

    // Simultaneous fetch and store: store first, then fetch back to back.
    if_req = 1'b1; if_addr = 32'h0000_0020;
    set_dt(1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
    push_bus(1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
    push_bus(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    expect_grant("s2.store");
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("s2.dt_ack",     32'(dt_ack), 32'h1);
    check("s2.rdata_keep", dt_rdata,    32'h0);
    expect_grant("s2.fetch");
    tick();
    dt_req = 1'b0;
    check("s2.dt_ack_clr", 32'(dt_ack),  32'h0);
    check("s2.hold_req",   32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("s2.if_ack",  32'(if_ack),  32'h1);
    check("s2.if_data", if_data,      32'h1234_5678);
    check("s2.idle",    32'(mem_req), 32'h0);
    tick();
    if_req = 1'b0;
    check("s2.no_regrant", 32'(mem_req), 32'h0);

    // Clock enable toggling around the memory ack of a load.
    base_dt = dt_ack_cnt;
    set_dt(1'b0, 4'h0, 32'h0000_0203, 32'h0BAD_0BAD);
    push_bus(1'b0, 4'hF, 32'h0000_0200, 32'h0BAD_0BAD);
    tick();
    expect_grant("ce.load");
    ce = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    check("ce.off_ack",   32'(dt_ack),  32'h0);
    check("ce.off_req",   32'(mem_req), 32'h1);
    check("ce.off_rdata", dt_rdata,     32'h0);
    ce = 1'b1;
    tick();
    check("ce.on_ack",   32'(dt_ack), 32'h1);
    check("ce.on_rdata", dt_rdata,    32'hA5A5_0001);
    ce = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
    tick(); tick();
    check("ce.frz_ack",   32'(dt_ack), 32'h1);
    check("ce.frz_rdata", dt_rdata,    32'hA5A5_0001);
    ce = 1'b1;
    tick();
    dt_req = 1'b0;
    check("ce.ack_clr",   32'(dt_ack),  32'h0);
    check("ce.no_regrant", 32'(mem_req), 32'h0);
    check("ce.ack_count", 32'(dt_ack_cnt - base_dt), 32'h1);

    // Reset while a store is stalled on the bus.
    base_dt = dt_ack_cnt;
    set_dt(1'b1, 4'hF, 32'h0000_0500, 32'h1111_2222);
    push_bus(1'b1, 4'hF, 32'h0000_0500, 32'h1111_2222);
    tick();
    expect_grant("rs.store");
    tick();
    rst_n = 1'b0;
    #1;
    check("rs.mem_req",  32'(mem_req), 32'h0);
    check("rs.mem_we",   32'(mem_we),  32'h0);
    check("rs.mem_be",   32'(mem_be),  32'h0);
    check("rs.mem_addr", mem_addr,     32'h0);
    check("rs.wdata",    mem_wdata,    32'h0);
    check("rs.if_data",  if_data,      32'h0);
    check("rs.dt_rdata", dt_rdata,     32'h0);
    mem_ack = 1'b1;
    tick();
    check("rs.dt_ack", 32'(dt_ack), 32'h0);
    dt_req = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rs.idle", 32'(mem_req), 32'h0);
    if_req = 1'b1; if_addr = 32'h0000_0600;
    push_bus(1'b0, 4'hF, 32'h0000_0600, 32'h0);
    tick();
    expect_grant("rs.after");
    mem_ack = 1'b1; mem_rdata = 32'h0000_600D;
    tick();
    mem_ack = 1'b0;
    check("rs.after_ack", 32'(if_ack), 32'h1);
    tick();
    if_req = 1'b0;
    check("rs.no_dt_ack", 32'(dt_ack_cnt - base_dt), 32'h0);

    // Fetch dropped after its grant still completes; pending load granted at the ack edge.
    base_if = if_ack_cnt;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    push_bus(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    tick();
    expect_grant("dr.fetch");
    if_req = 1'b0;
    set_dt(1'b0, 4'hF, 32'h0000_0300, 32'h0);
    push_bus(1'b0, 4'hF, 32'h0000_0300, 32'h0);
    tick();
    check("dr.frozen", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0;
    check("dr.if_ack",  32'(if_ack), 32'h1);
    check("dr.if_data", if_data,     32'h0000_0077);
    expect_grant("dr.load");
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0088;
    tick();
    mem_ack = 1'b0;
    check("dr.dt_rdata", dt_rdata, 32'h0000_0088);
    tick();
    dt_req = 1'b0;
    check("dr.if_count", 32'(if_ack_cnt - base_if), 32'h1);

    // Starvation override with STARVE_MAX = 2: D, D while fetch pending, then F, then D.
    for (int k = 0; k < 2; k++) begin
      if_req = 1'b1; if_addr = 32'h0000_0050 + 32'(k * 4);
      set_dt(1'b0, 4'hF, 32'h0000_0400 + 32'(k * 4), 32'h0);
      push_bus(1'b0, 4'hF, 32'h0000_0400 + 32'(k * 4), 32'h0);
      tick();
      expect_grant("sv.data");
      if_req = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'(k);
      tick();
      mem_ack = 1'b0;
      check("sv.data_ack", 32'(dt_ack), 32'h1);
      tick();
      dt_req = 1'b0;
      check("sv.idle", 32'(mem_req), 32'h0);
    end
    if_req = 1'b1; if_addr = 32'h0000_0058;
    set_dt(1'b0, 4'hF, 32'h0000_0408, 32'h0);
    push_bus(1'b0, 4'hF, 32'h0000_0058, 32'h0);
    push_bus(1'b0, 4'hF, 32'h0000_0408, 32'h0);
    tick();
    expect_grant("sv.fetch_wins");
    mem_ack = 1'b1; mem_rdata = 32'h0000_5858;
    tick();
    mem_ack = 1'b0;
    expect_grant("sv.data_next");
    tick();
    if_req = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    dt_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_005C;
    set_dt(1'b0, 4'hF, 32'h0000_040C, 32'h0);
    push_bus(1'b0, 4'hF, 32'h0000_040C, 32'h0);
    push_bus(1'b0, 4'hF, 32'h0000_005C, 32'h0);
    tick();
    expect_grant("sv.cleared_data");
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_grant("sv.cleared_fetch");
    tick();
    dt_req = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    if_req = 1'b0;
    check("end.idle",     32'(mem_req),     32'h0);
    check("end.sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
